// File: rtl/adc_trg_pkg.sv
// Shared definitions for the ADC trigger decoder and the matching trigger
// generator: default cadence parameters and the decoder state encoding.
package adc_trg_pkg;

   localparam int unsigned DEF_HALF_PERIOD = 50000;
   localparam int unsigned DEF_TOL         = 16;
   localparam int unsigned DEF_LOCK_N      = 4;
   localparam int unsigned DEF_CNT_W       = 20;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ACQUIRE = 3'd1,
      ST_MEASURE = 3'd2,
      ST_LOCKED  = 3'd3,
      ST_LOST    = 3'd4
   } trg_state_t;

endpackage

// File: rtl/trg_sync_edge.sv
// Two-flop synchroniser for the asynchronous trigger followed by a
// previous-value register; either polarity of change is reported as an edge.
module trg_sync_edge (
   input  logic fpga_clk,
   input  logic fpga_rst_n,
   input  logic trg_async,
   output logic edge_det
);

   logic sync1_reg;
   logic sync2_reg;
   logic prev_reg;

   // Synchroniser chain plus history register; runs regardless of enable
   always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         prev_reg  <= 1'b0;
      end else begin
         sync1_reg <= trg_async;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
      end
   end

   assign edge_det = sync2_reg ^ prev_reg;

endmodule

// File: rtl/adc_trg_decoder.sv
// Decodes a toggling ADC trigger into sample strobes, measures the interval
// between toggles and tracks whether the cadence is within tolerance.
module adc_trg_decoder
   import adc_trg_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = DEF_HALF_PERIOD,
   parameter int unsigned TOL         = DEF_TOL,
   parameter int unsigned LOCK_N      = DEF_LOCK_N,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic             fpga_clk,
   input  logic             fpga_rst_n,
   input  logic             adc_en,
   input  logic             adc_trg_in,
   input  logic             err_clr,
   output logic             sample_strobe,
   output logic [31:0]      sample_idx,
   output logic [CNT_W-1:0] half_period,
   output logic             locked,
   output logic             err_early,
   output logic             err_late
);

   localparam int GC_W = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
   localparam logic [GC_W-1:0]  LOCK_N_C = GC_W'(LOCK_N);
   localparam logic [CNT_W-1:0] LO_LIM   = CNT_W'(HALF_PERIOD - TOL);
   localparam logic [CNT_W-1:0] HI_LIM   = CNT_W'(HALF_PERIOD + TOL);
   localparam logic [CNT_W-1:0] LATE_LIM = CNT_W'(HALF_PERIOD + TOL + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   trg_state_t       state_reg;
   logic             strobe_reg;
   logic [31:0]      idx_reg;
   logic [CNT_W-1:0] int_cnt_reg;
   logic [CNT_W-1:0] half_period_reg;
   logic [GC_W-1:0]  good_cnt_reg;
   logic             locked_reg;
   logic             err_early_reg;
   logic             err_late_reg;

   logic            trg_edge;
   logic            run;
   logic            iv_good;
   logic            iv_early;
   logic            early_hit;
   logic            late_hit;
   logic [GC_W-1:0] good_inc;

   trg_sync_edge u_sync (
      .fpga_clk   (fpga_clk),
      .fpga_rst_n (fpga_rst_n),
      .trg_async  (adc_trg_in),
      .edge_det   (trg_edge)
   );

   // Edges only count once the decoder has left IDLE with the enable still high
   assign run       = adc_en && (state_reg != ST_IDLE);
   assign iv_good   = (int_cnt_reg >= LO_LIM) && (int_cnt_reg <= HI_LIM);
   assign iv_early  = (int_cnt_reg < LO_LIM);
   assign early_hit = run && (state_reg == ST_LOCKED) && trg_edge && iv_early;
   // An edge on the timeout cycle takes priority over the timeout
   assign late_hit  = run && (state_reg == ST_LOCKED) && !trg_edge && (int_cnt_reg == LATE_LIM);
   assign good_inc  = good_cnt_reg + GC_W'(1);

   // Interval counter: restarts at 1 on each edge, saturates at full scale
   always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         int_cnt_reg <= '0;
      end else if (!run) begin
         int_cnt_reg <= '0;
      end else if (trg_edge) begin
         int_cnt_reg <= CNT_W'(1);
      end else if (int_cnt_reg != CNT_MAX) begin
         int_cnt_reg <= int_cnt_reg + CNT_W'(1);
      end
   end

   // Strobe pulse and running sample index
   always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         strobe_reg <= 1'b0;
         idx_reg    <= '0;
      end else if (!adc_en) begin
         strobe_reg <= 1'b0;
         idx_reg    <= '0;
      end else if (!run) begin
         strobe_reg <= 1'b0;
      end else begin
         strobe_reg <= trg_edge;
         if (trg_edge) begin
            idx_reg <= idx_reg + 32'd1;
         end
      end
   end

   // Cadence FSM with registered lock flag and measured interval
   always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         state_reg       <= ST_IDLE;
         good_cnt_reg    <= '0;
         locked_reg      <= 1'b0;
         half_period_reg <= '0;
      end else if (!adc_en) begin
         state_reg    <= ST_IDLE;
         good_cnt_reg <= '0;
         locked_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               state_reg <= ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
               // First edge only starts the interval; nothing to measure yet
               if (trg_edge) begin
                  state_reg    <= ST_MEASURE;
                  good_cnt_reg <= '0;
               end
            end
            ST_MEASURE: begin
               if (trg_edge) begin
                  half_period_reg <= int_cnt_reg;
                  if (iv_good) begin
                     good_cnt_reg <= good_inc;
                     if (good_inc >= LOCK_N_C) begin
                        state_reg  <= ST_LOCKED;
                        locked_reg <= 1'b1;
                     end
                  end else begin
                     good_cnt_reg <= '0;
                  end
               end
            end
            ST_LOCKED: begin
               if (trg_edge) begin
                  half_period_reg <= int_cnt_reg;
                  if (!iv_good) begin
                     state_reg    <= ST_MEASURE;
                     good_cnt_reg <= '0;
                     locked_reg   <= 1'b0;
                  end
               end else if (late_hit) begin
                  state_reg  <= ST_LOST;
                  locked_reg <= 1'b0;
               end
            end
            ST_LOST: begin
               if (trg_edge) begin
                  half_period_reg <= int_cnt_reg;
                  state_reg       <= ST_MEASURE;
                  good_cnt_reg    <= '0;
               end
            end
            default: begin
               state_reg  <= ST_IDLE;
               locked_reg <= 1'b0;
            end
         endcase
      end
   end

   // Sticky error flags; a new error beats a simultaneous clear
   always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         err_early_reg <= 1'b0;
         err_late_reg  <= 1'b0;
      end else begin
         if (early_hit) begin
            err_early_reg <= 1'b1;
         end else if (err_clr) begin
            err_early_reg <= 1'b0;
         end
         if (late_hit) begin
            err_late_reg <= 1'b1;
         end else if (err_clr) begin
            err_late_reg <= 1'b0;
         end
      end
   end

   assign sample_strobe = strobe_reg;
   assign sample_idx    = idx_reg;
   assign half_period   = half_period_reg;
   assign locked        = locked_reg;
   assign err_early     = err_early_reg;
   assign err_late      = err_late_reg;

endmodule

// File: tb/tb_adc_trg_decoder.sv
// Bench for adc_trg_decoder with a timestamp-based cadence model and
// directed trigger sequences.
`timescale 1ns/1ps
module tb_adc_trg_decoder;

   localparam int HP  = 100;
   localparam int TL  = 2;
   localparam int LN  = 4;
   localparam int CW  = 20;
   localparam int LO  = HP - TL;
   localparam int HI  = HP + TL;
   localparam longint CMAX = (longint'(1) << CW) - 1;

   logic          fpga_clk   = 1'b0;
   logic          fpga_rst_n = 1'b0;
   logic          adc_en     = 1'b0;
   logic          adc_trg_in = 1'b0;
   logic          err_clr    = 1'b0;
   logic          sample_strobe;
   logic [31:0]   sample_idx;
   logic [CW-1:0] half_period;
   logic          locked;
   logic          err_early;
   logic          err_late;

   int checks = 0;
   int errors = 0;
   int since  = 0;

   always #5 fpga_clk = ~fpga_clk;

   adc_trg_decoder #(
      .HALF_PERIOD (HP),
      .TOL         (TL),
      .LOCK_N      (LN),
      .CNT_W       (CW)
   ) dut (
      .fpga_clk      (fpga_clk),
      .fpga_rst_n    (fpga_rst_n),
      .adc_en        (adc_en),
      .adc_trg_in    (adc_trg_in),
      .err_clr       (err_clr),
      .sample_strobe (sample_strobe),
      .sample_idx    (sample_idx),
      .half_period   (half_period),
      .locked        (locked),
      .err_early     (err_early),
      .err_late      (err_late)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Works in absolute cycle timestamps: an input change is seen as an event
   // when the trigger sampled two and three clocks earlier differ, and the
   // interval is the distance between event timestamps.
   typedef enum int {M_IDLE, M_ACQ, M_MEAS, M_LOCK, M_LOST} mode_t;
   mode_t       m_mode;
   longint      k_now;
   longint      last_k;
   longint      iv;
   logic        s1, s2, s3;
   logic        ev;
   logic        set_e, set_l;
   int          good_n;
   logic        m_strobe;
   logic [31:0] m_idx;
   logic [63:0] m_hp;
   logic        m_locked;
   logic        m_early;
   logic        m_late;

   always @(posedge fpga_clk or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         m_mode = M_IDLE; k_now = 0; last_k = 0;
         s1 = 0; s2 = 0; s3 = 0;
         good_n = 0; m_strobe = 0; m_idx = 0; m_hp = 0;
         m_locked = 0; m_early = 0; m_late = 0;
      end else begin
         k_now++;
         ev = (s2 != s3);
         s3 = s2; s2 = s1; s1 = adc_trg_in;
         set_e = 0; set_l = 0;
         if (!adc_en) begin
            m_mode = M_IDLE; m_idx = 0; m_strobe = 0; good_n = 0;
         end else if (m_mode == M_IDLE) begin
            m_mode = M_ACQ; m_strobe = 0;
         end else begin
            m_strobe = ev;
            if (ev) begin
               m_idx = m_idx + 1;
               iv = k_now - last_k;
               if (iv > CMAX) iv = CMAX;
               last_k = k_now;
               case (m_mode)
                  M_ACQ: begin m_mode = M_MEAS; good_n = 0; end
                  M_MEAS: begin
                     m_hp = iv;
                     if (iv >= LO && iv <= HI) begin
                        good_n++;
                        if (good_n >= LN) m_mode = M_LOCK;
                     end else good_n = 0;
                  end
                  M_LOCK: begin
                     m_hp = iv;
                     if (iv < LO) begin set_e = 1; m_mode = M_MEAS; good_n = 0; end
                     else if (iv > HI) begin m_mode = M_MEAS; good_n = 0; end
                  end
                  default: begin m_hp = iv; m_mode = M_MEAS; good_n = 0; end
               endcase
            end else if (m_mode == M_LOCK && (k_now - last_k) == HI + 1) begin
               set_l = 1; m_mode = M_LOST;
            end
         end
         m_locked = (m_mode == M_LOCK);
         if (set_e) m_early = 1; else if (err_clr) m_early = 0;
         if (set_l) m_late = 1; else if (err_clr) m_late = 0;
      end
   end

   // Compare every cycle away from the active edge
   always @(negedge fpga_clk) begin
      if (fpga_rst_n) begin
         check("m_strobe", sample_strobe, m_strobe);
         check("m_idx", sample_idx, m_idx);
         check("m_half_period", half_period, m_hp);
         check("m_locked", locked, m_locked);
         check("m_err_early", err_early, m_early);
         check("m_err_late", err_late, m_late);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge fpga_clk);
         since++;
      end
   endtask

   task automatic toggle_now();
      adc_trg_in = ~adc_trg_in;
      since = 0;
   endtask

   task automatic toggle_at(input int gap);
      tick(gap - since);
      toggle_now();
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_strobe"}, sample_strobe, 0);
      check({tag, "_idx"}, sample_idx, 0);
      check({tag, "_hp"}, half_period, 0);
      check({tag, "_locked"}, locked, 0);
      check({tag, "_err_early"}, err_early, 0);
      check({tag, "_err_late"}, err_late, 0);
   endtask

   initial begin
      #3;
      check_zero_outputs("reset");
      repeat (2) @(negedge fpga_clk);
      fpga_rst_n = 1'b1;
      tick(2);
      adc_en = 1'b1;
      tick(5);

      // Lock after five 100-cycle toggles
      toggle_now();
      tick(3);
      check("first_strobe", sample_strobe, 1);
      check("first_idx", sample_idx, 1);
      check("first_hp_unloaded", half_period, 0);
      repeat (3) toggle_at(100);
      tick(3);
      check("pre_lock_locked", locked, 0);
      check("pre_lock_idx", sample_idx, 4);
      toggle_at(100);
      tick(3);
      check("lock_strobe", sample_strobe, 1);
      check("lock_locked", locked, 1);
      check("lock_idx", sample_idx, 5);
      check("lock_hp", half_period, 100);
      $display("txn lock: idx=%0d hp=%0d locked=%0d", sample_idx, half_period, locked);

      // Early toggle then relock
      toggle_at(97);
      tick(3);
      check("early_flag", err_early, 1);
      check("early_locked", locked, 0);
      check("early_hp", half_period, 97);
      repeat (3) toggle_at(100);
      tick(3);
      check("relock_pending", locked, 0);
      toggle_at(100);
      tick(3);
      check("relock_locked", locked, 1);
      check("relock_err_sticky", err_early, 1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("early_cleared", err_early, 0);
      $display("txn early: relocked=%0d err_early=%0d", locked, err_early);

      // Stop toggling: timeout 103 cycles after the last strobe, clear loses
      tick(105 - since);
      check("late_not_yet", err_late, 0);
      check("late_not_yet_locked", locked, 1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("late_beats_clr", err_late, 1);
      check("late_locked", locked, 0);
      tick(5);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("late_cleared", err_late, 0);
      toggle_at(300);
      tick(3);
      check("lost_edge_strobe", sample_strobe, 1);
      check("lost_edge_hp", half_period, 300);
      check("lost_edge_locked", locked, 0);
      repeat (4) toggle_at(100);
      tick(3);
      check("lost_relock", locked, 1);
      $display("txn late: err_late=%0d locked=%0d hp=%0d", err_late, locked, half_period);

      // Disable mid-lock then re-enable with a quiet trigger
      adc_en = 1'b0;
      tick(3);
      check("dis_idx", sample_idx, 0);
      check("dis_locked", locked, 0);
      check("dis_hp_held", half_period, 100);
      adc_en = 1'b1;
      tick(30);
      check("reen_idx", sample_idx, 0);
      check("reen_strobe", sample_strobe, 0);
      check("reen_hp_held", half_period, 100);
      $display("txn reenable: idx=%0d hp=%0d", sample_idx, half_period);

      // Tolerance edges 98/102 lock; 90 is early
      toggle_now();
      toggle_at(98);
      toggle_at(102);
      toggle_at(98);
      toggle_at(102);
      tick(3);
      check("tol_locked", locked, 1);
      check("tol_hp", half_period, 102);
      check("tol_idx", sample_idx, 5);
      toggle_at(90);
      repeat (4) toggle_at(100);
      tick(3);
      check("tol_relock", locked, 1);
      check("tol_err_early", err_early, 1);
      $display("txn tolerance: locked=%0d err_early=%0d", locked, err_early);

      // Short asynchronous reset between clocks
      tick(1);
      #2;
      fpga_rst_n = 1'b0;
      #0.5;
      check_zero_outputs("async_rst");
      #0.5;
      fpga_rst_n = 1'b1;
      tick(10);
      $display("txn reset: locked=%0d idx=%0d", locked, sample_idx);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_trg_decoder.md
ADC_TRG_DECODER -- requirements
Module: adc_trg_decoder

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 50000, the nominal fpga_clk cycles between trigger toggles.
REQ-002 SHALL have parameter TOL, default 16, the allowed +/- cycle deviation per interval.
REQ-003 SHALL have parameter LOCK_N, default 4, the consecutive in-tolerance intervals required to lock.
REQ-004 SHALL have parameter CNT_W, default 20, the width of the interval counter and half_period.
REQ-005 fpga_clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-006 fpga_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 adc_en  input  1  synchronous enable; low forces IDLE.
REQ-008 adc_trg_in  input  1  toggling trigger, asynchronous to fpga_clk.
REQ-009 err_clr  input  1  single-cycle pulse that clears sticky error flags.
REQ-010 sample_strobe  output  1  one-cycle pulse per detected trigger toggle.
REQ-011 sample_idx  output  32  count of strobes since enable.
REQ-012 half_period  output  CNT_W  last measured edge-to-edge interval.
REQ-013 locked  output  1  high while the trigger cadence is in tolerance.
REQ-014 err_early, err_late  output  1 each  sticky cadence-error flags.

Function
REQ-015 SHALL pass adc_trg_in through a 2-flop synchroniser, then a previous-value register; an edge is sync2 != prev.
REQ-016 Both edge polarities SHALL be trigger events; sample_strobe SHALL be high on the 3rd fpga_clk rising edge after an adc_trg_in transition meets setup.
REQ-017 sample_idx SHALL increment with each sample_strobe and wrap from 2^32-1 to 0.
REQ-018 The interval counter SHALL reset to 1 on the strobe cycle, else increment, saturating at 2^CNT_W-1.
REQ-019 On every strobe except the first after entering ACQUIRE, half_period SHALL load the interval counter value.
REQ-020 An interval is good iff HALF_PERIOD-TOL <= interval <= HALF_PERIOD+TOL.
REQ-021 FSM states SHALL be IDLE, ACQUIRE, MEASURE, LOCKED and LOST.
REQ-022 Transition IDLE->ACQUIRE when adc_en=1.
REQ-023 Transition ACQUIRE->MEASURE on the first edge.
REQ-024 In MEASURE, a good interval SHALL increment good_cnt; on reaching LOCK_N the FSM SHALL go to LOCKED; a bad interval SHALL reset good_cnt to 0.
REQ-025 In LOCKED, an interval < HALF_PERIOD-TOL SHALL set err_early and go to MEASURE with good_cnt=0.
REQ-026 In LOCKED, when the interval counter reaches HALF_PERIOD+TOL+1 with no edge, err_late SHALL be set and the FSM SHALL go to LOST.
REQ-027 In LOST, the next edge SHALL go to MEASURE with good_cnt=0; that edge SHALL still strobe.
REQ-028 adc_en=0 in any state SHALL go to IDLE next cycle and zero sample_idx, the interval counter, good_cnt and locked; half_period and the error flags SHALL hold.
REQ-029 In IDLE, no strobes SHALL be generated; the synchroniser SHALL keep running, so re-enable does not produce a false edge.
REQ-030 locked SHALL be a registered decode of state==LOCKED.
REQ-031 err_clr and a new error in the same cycle: the error SHALL win (flag stays 1).
REQ-032 An edge and the late-timeout in the same cycle: the edge SHALL win (no err_late).

Reset
REQ-033 fpga_rst_n=0 SHALL immediately set: state=IDLE; all outputs 0; half_period=0; synchroniser and prev=0; counters=0.
REQ-034 Deassertion SHALL be used synchronously; the first active cycle is IDLE.
REQ-035 Reset mid-LOCKED SHALL lose all history, including the error flags.

Structure
REQ-036 State encoding and default HALF_PERIOD/TOL/LOCK_N SHALL live in shared package adc_trg_pkg, used with the trigger generator.
REQ-037 The synchroniser plus edge detect SHALL be sub-module trg_sync_edge; all else SHALL be flat.

Verification (HALF_PERIOD=100, TOL=2, LOCK_N=4)
REQ-038 adc_en=1, toggle every 100 cycles -> locked=1 after the 5th edge; sample_idx=5; half_period=100.
REQ-039 Locked; one toggle at 97 cycles -> err_early=1, locked=0; 4 further 100-cycle intervals -> locked=1 again.
REQ-040 Locked; stop toggling -> err_late=1 and state LOST exactly 103 cycles after the last strobe; the next edge strobes; state=MEASURE.
REQ-041 err_clr pulsed on the same cycle as the late timeout -> err_late remains 1; a lone err_clr later -> 0.
REQ-042 adc_en dropped mid-LOCKED, then restored with no trigger change -> no strobe; sample_idx=0; half_period retained.
REQ-043 fpga_rst_n pulsed low for 1 ns between clocks while locked -> all outputs 0 immediately.
